// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of writeback entries. With WB_PENDING_MASK_EN defined it also
// exposes every slot and its valid bit so the top can build the pending mask.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             push,
    input  wb_entry_t        pushEntry,
    input  logic             pop,
    output wb_entry_t        headEntry,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
`ifdef WB_PENDING_MASK_EN
    ,
    output wb_entry_t        slots [DEPTH],
    output logic [DEPTH-1:0] slotValid
`endif
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush    = push && !full;
    assign doPop     = pop && !empty;
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign headEntry = mem[rdPtr];

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            if (doPush && !doPop)      count <= count + CNT_W'(1);
            else if (!doPush && doPop) count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; slot validity comes from the pointers alone.
    always_ff @(posedge CLOCK) begin
        if (doPush) mem[wrPtr] <= pushEntry;
    end

`ifdef WB_PENDING_MASK_EN
    assign slots = mem;

    // A slot is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PTR_W-1:0] age;
        assign age          = PTR_W'(i) - rdPtr;
        assign slotValid[i] = CNT_W'(age) < count;
    end
`endif

endmodule

// File: rtl/regfile_writeback_unit.sv
// Writeback initiator: arbitrates ALU/MEM results into an in-order queue and
// retires one register write per cycle. Optional macro: WB_PENDING_MASK_EN.
module regfile_writeback_unit
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          CLOCK,
    input  logic                          RESET_N,
    input  logic                          alu_valid,
    input  logic [REG_ADDR_W-1:0]         alu_addr,
    input  logic [REG_DATA_W-1:0]         alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [REG_ADDR_W-1:0]         mem_addr,
    input  logic [REG_DATA_W-1:0]         mem_data,
    output logic                          mem_ready,
    output logic [REG_ADDR_W-1:0]         writeAddress,
    output logic [REG_DATA_W-1:0]         writeData,
    output logic                          regWrite,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic [31:0]                   pending_mask
);

    wb_entry_t inEntry;
    wb_entry_t headEntry;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      memTake;
    logic      aluTake;

    // Ready looks only at registered full and mem_valid; MEM has priority.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign memTake   = mem_valid && mem_ready;
    assign aluTake   = alu_valid && alu_ready;

    always_comb begin
        inEntry.addr = alu_addr;
        inEntry.data = alu_data;
        if (mem_valid) begin
            inEntry.addr = mem_addr;
            inEntry.data = mem_data;
        end
    end

    // XZR writes complete the handshake but are dropped here.
    assign push = (memTake || aluTake) && (inEntry.addr != XZR_ADDR);
    assign pop  = !empty;

`ifdef WB_PENDING_MASK_EN
    wb_entry_t        slots [DEPTH];
    logic [DEPTH-1:0] slotValid;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .push      (push),
        .pushEntry (inEntry),
        .pop       (pop),
        .headEntry (headEntry),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
`ifdef WB_PENDING_MASK_EN
        ,
        .slots     (slots),
        .slotValid (slotValid)
`endif
    );

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            regWrite     <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
        end else begin
            regWrite <= pop;
            if (pop) begin
                writeAddress <= headEntry.addr;
                writeData    <= headEntry.data;
            end
        end
    end

`ifdef WB_PENDING_MASK_EN
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotValid[i]) pending_mask[slots[i].addr] = 1'b1;
        end
        if (regWrite) pending_mask[writeAddress] = 1'b1;
        pending_mask[XZR_ADDR] = 1'b0;
    end
`else
    assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Randomised and directed bench for regfile_writeback_unit against a queue model.
module tb_regfile_writeback_unit;
    import regfile_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef WB_PENDING_MASK_EN
    localparam logic [31:0] MASK_ON = '1;
`else
    localparam logic [31:0] MASK_ON = '0;
`endif

    logic             CLOCK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             alu_valid = 1'b0;
    logic [4:0]       alu_addr = '0;
    logic [63:0]      alu_data = '0;
    logic             mem_valid = 1'b0;
    logic [4:0]       mem_addr = '0;
    logic [63:0]      mem_data = '0;
    logic             alu_ready;
    logic             mem_ready;
    logic [4:0]       writeAddress;
    logic [63:0]      writeData;
    logic             regWrite;
    logic [CNT_W-1:0] occupancy;
    logic [31:0]      pending_mask;

    int nTests = 0;
    int nFail  = 0;

    typedef struct { logic [4:0] a; logic [63:0] d; } ment_t;
    ment_t       mq[$];
    logic        mRegWrite = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [63:0] mData = '0;
    logic        stall = 1'b0;
    logic        sAluRdy, sMemRdy, eAluRdy, eMemRdy;

    always #5 CLOCK = ~CLOCK;

    regfile_writeback_unit #(.DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .writeAddress(writeAddress), .writeData(writeData), .regWrite(regWrite),
        .occupancy(occupancy), .pending_mask(pending_mask)
    );

    function automatic logic [31:0] modelMask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        if (mRegWrite) m[mAddr] = 1'b1;
        m[31] = 1'b0;
        return m & MASK_ON;
    endfunction

    // Drive one cycle, sample readys before the edge, advance the model.
    task automatic tick(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [63:0] md);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        #2;
        sAluRdy = alu_ready; sMemRdy = mem_ready;
        eMemRdy = (mq.size() < DEPTH);
        eAluRdy = eMemRdy && !mv;
        @(posedge CLOCK);
        if (!stall && mq.size() > 0) begin
            mRegWrite = 1'b1; mAddr = mq[0].a; mData = mq[0].d;
            void'(mq.pop_front());
        end else begin
            mRegWrite = 1'b0;
        end
        if (mv && eMemRdy) begin
            if (ma != 5'd31) mq.push_back('{ma, md});
        end else if (av && eAluRdy && aa != 5'd31) begin
            mq.push_back('{aa, ad});
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge CLOCK); #1;
        mq.delete(); mRegWrite = 1'b0; mAddr = '0; mData = '0;
    endtask

    task automatic test_reset();
        do_reset();
        nTests++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin nFail++; $display("FAIL reset_ready: got alu=%b mem=%b expected 1 1", alu_ready, mem_ready); end
        nTests++; if (regWrite !== 1'b0) begin nFail++; $display("FAIL reset_regWrite: got %b expected 0", regWrite); end
        nTests++; if (writeAddress !== 5'd0 || writeData !== 64'd0) begin nFail++; $display("FAIL reset_wport: got %0d/%h expected 0/0", writeAddress, writeData); end
        nTests++; if (occupancy !== '0) begin nFail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        nTests++; if (pending_mask !== 32'd0) begin nFail++; $display("FAIL reset_mask: got %h expected 0", pending_mask); end
        RESET_N = 1'b1;
    endtask

    task automatic test_single_alu();
        tick(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        nTests++; if (sAluRdy !== 1'b1) begin nFail++; $display("FAIL single_ready: got %b expected 1", sAluRdy); end
        nTests++; if (occupancy !== CNT_W'(1) || regWrite !== 1'b0) begin nFail++; $display("FAIL single_accept: got occ=%0d rw=%b expected 1 0", occupancy, regWrite); end
        nTests++; if (pending_mask !== (MASK_ON & 32'h20)) begin nFail++; $display("FAIL single_mask_q: got %h expected %h", pending_mask, MASK_ON & 32'h20); end
        idle();
        nTests++; if (regWrite !== 1'b1 || writeAddress !== 5'd5 || writeData !== 64'h1234) begin nFail++; $display("FAIL single_write: got rw=%b a=%0d d=%h expected 1 5 1234", regWrite, writeAddress, writeData); end
        nTests++; if (occupancy !== '0) begin nFail++; $display("FAIL single_occ: got %0d expected 0", occupancy); end
        nTests++; if (pending_mask !== (MASK_ON & 32'h20)) begin nFail++; $display("FAIL single_mask_port: got %h expected %h", pending_mask, MASK_ON & 32'h20); end
        idle();
        nTests++; if (regWrite !== 1'b0 || writeAddress !== 5'd5 || pending_mask !== 32'd0) begin nFail++; $display("FAIL single_done: got rw=%b a=%0d m=%h expected 0 5 0", regWrite, writeAddress, pending_mask); end
    endtask

    task automatic test_arbitration();
        tick(1'b1, 5'd3, 64'hBB, 1'b1, 5'd2, 64'hAA);
        nTests++; if (sMemRdy !== 1'b1 || sAluRdy !== 1'b0) begin nFail++; $display("FAIL arb_ready: got mem=%b alu=%b expected 1 0", sMemRdy, sAluRdy); end
        tick(1'b1, 5'd3, 64'hBB, 1'b0, 5'd0, 64'd0);
        nTests++; if (sAluRdy !== 1'b1) begin nFail++; $display("FAIL arb_alu_ready: got %b expected 1", sAluRdy); end
        nTests++; if (regWrite !== 1'b1 || writeAddress !== 5'd2 || writeData !== 64'hAA) begin nFail++; $display("FAIL arb_first: got rw=%b a=%0d d=%h expected 1 2 aa", regWrite, writeAddress, writeData); end
        idle();
        nTests++; if (regWrite !== 1'b1 || writeAddress !== 5'd3 || writeData !== 64'hBB) begin nFail++; $display("FAIL arb_second: got rw=%b a=%0d d=%h expected 1 3 bb", regWrite, writeAddress, writeData); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ta [4];
        logic [63:0] td [4];
        logic [4:0]  gotA[$];
        logic [63:0] gotD[$];
        ta = '{5'd7, 5'd7, 5'd9, 5'd10};
        td = '{64'd1, 64'd2, 64'd3, 64'd4};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) tick(1'b1, ta[i], td[i], 1'b0, 5'd0, 64'd0);
            else idle();
            nTests++; if (occupancy > CNT_W'(1)) begin nFail++; $display("FAIL b2b_occ[%0d]: got %0d expected <=1", i, occupancy); end
            nTests++; if (pending_mask[7] !== (MASK_ON[0] & (i <= 2))) begin nFail++; $display("FAIL b2b_mask7[%0d]: got %b expected %b", i, pending_mask[7], MASK_ON[0] & (i <= 2)); end
            if (regWrite === 1'b1) begin gotA.push_back(writeAddress); gotD.push_back(writeData); end
        end
        nTests++; if (gotA.size() != 4) begin nFail++; $display("FAIL b2b_count: got %0d expected 4", gotA.size()); end
        for (int i = 0; i < 4 && i < gotA.size(); i++) begin
            nTests++; if (gotA[i] !== ta[i] || gotD[i] !== td[i]) begin nFail++; $display("FAIL b2b_order[%0d]: got %0d/%0d expected %0d/%0d", i, gotA[i], gotD[i], ta[i], td[i]); end
        end
    endtask

    task automatic test_xzr();
        tick(1'b1, 5'd31, 64'hFF, 1'b0, 5'd0, 64'd0);
        nTests++; if (sAluRdy !== 1'b1) begin nFail++; $display("FAIL xzr_ready: got %b expected 1", sAluRdy); end
        nTests++; if (occupancy !== '0 || regWrite !== 1'b0) begin nFail++; $display("FAIL xzr_accept: got occ=%0d rw=%b expected 0 0", occupancy, regWrite); end
        nTests++; if (pending_mask !== 32'd0) begin nFail++; $display("FAIL xzr_mask: got %h expected 0", pending_mask); end
        idle();
        nTests++; if (regWrite !== 1'b0) begin nFail++; $display("FAIL xzr_nowrite: got %b expected 0", regWrite); end
    endtask

    task automatic test_full_stall();
        force dut.pop = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, 5'(i + 1), 64'(100 + i), 1'b0, 5'd0, 64'd0);
        nTests++; if (occupancy !== CNT_W'(4)) begin nFail++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
        nTests++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin nFail++; $display("FAIL full_ready: got alu=%b mem=%b expected 0 0", alu_ready, mem_ready); end
        nTests++; if (pending_mask !== (MASK_ON & 32'h1E)) begin nFail++; $display("FAIL full_mask: got %h expected %h", pending_mask, MASK_ON & 32'h1E); end
        release dut.pop; stall = 1'b0;
        tick(1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 64'd0);
        nTests++; if (sAluRdy !== 1'b0) begin nFail++; $display("FAIL drain_ready: got %b expected 0", sAluRdy); end
        nTests++; if (regWrite !== 1'b1 || writeAddress !== 5'd1 || occupancy !== CNT_W'(3)) begin nFail++; $display("FAIL drain_edge: got rw=%b a=%0d occ=%0d expected 1 1 3", regWrite, writeAddress, occupancy); end
        alu_valid = 1'b0; #1;
        nTests++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin nFail++; $display("FAIL drain_reopen: got alu=%b mem=%b expected 1 1", alu_ready, mem_ready); end
        for (int i = 0; i < 4; i++) begin
            idle();
            nTests++; if (regWrite !== mRegWrite || writeAddress !== mAddr || writeData !== mData) begin nFail++; $display("FAIL drain_seq[%0d]: got %b/%0d/%h expected %b/%0d/%h", i, regWrite, writeAddress, writeData, mRegWrite, mAddr, mData); end
        end
    endtask

    task automatic test_reset_midop();
        force dut.pop = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 5'(11 + i), 64'(200 + i), 1'b0, 5'd0, 64'd0);
        nTests++; if (occupancy !== CNT_W'(3)) begin nFail++; $display("FAIL midrst_fill: got %0d expected 3", occupancy); end
        release dut.pop; stall = 1'b0;
        do_reset();
        nTests++; if (occupancy !== '0 || regWrite !== 1'b0) begin nFail++; $display("FAIL midrst_state: got occ=%0d rw=%b expected 0 0", occupancy, regWrite); end
        nTests++; if (writeAddress !== 5'd0 || writeData !== 64'd0 || pending_mask !== 32'd0) begin nFail++; $display("FAIL midrst_out: got %0d/%h/%h expected 0/0/0", writeAddress, writeData, pending_mask); end
        RESET_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            nTests++; if (regWrite !== 1'b0 || writeAddress !== 5'd0) begin nFail++; $display("FAIL midrst_quiet[%0d]: got rw=%b a=%0d expected 0 0", i, regWrite, writeAddress); end
        end
    endtask

    task automatic test_random();
        logic st;
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 4) == 0);
            if (st) begin force dut.pop = 1'b0; stall = 1'b1; end
            else begin release dut.pop; stall = 1'b0; end
            tick(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom(), $urandom()});
            nTests++; if (sAluRdy !== eAluRdy || sMemRdy !== eMemRdy) begin nFail++; $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", n, sAluRdy, sMemRdy, eAluRdy, eMemRdy); end
            nTests++; if (regWrite !== mRegWrite) begin nFail++; $display("FAIL rnd_regWrite[%0d]: got %b expected %b", n, regWrite, mRegWrite); end
            nTests++; if (writeAddress !== mAddr || writeData !== mData) begin nFail++; $display("FAIL rnd_wport[%0d]: got %0d/%h expected %0d/%h", n, writeAddress, writeData, mAddr, mData); end
            nTests++; if (occupancy !== CNT_W'(mq.size())) begin nFail++; $display("FAIL rnd_occ[%0d]: got %0d expected %0d", n, occupancy, mq.size()); end
            nTests++; if (pending_mask !== modelMask()) begin nFail++; $display("FAIL rnd_mask[%0d]: got %h expected %h", n, pending_mask, modelMask()); end
        end
        release dut.pop; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_arbitration();
        test_back_to_back();
        test_xzr();
        test_full_stall();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
